// File: rtl/muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter_unit
//  Description : Iterative HI/LO multiply/divide unit (MULT/DIV/MADD/MSUB,
//                signed and unsigned). Radix-2 shift-add multiply and
//                restoring divide, one bit per cycle, start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct,
    input  logic             clear,
    input  logic             hold_result,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             write_hi_lo
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [2:0]       r_op;
    logic             r_neg;
    logic             r_neg_rem;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi_out;
    logic [WIDTH-1:0] r_lo_out;
    logic             r_busy;
    logic             r_done;
    logic             r_wr;

    // Operation decode: funct[0]=unsigned, 2/3 divide, 4..7 accumulate, 6/7 subtract
    logic w_signed, w_sign_a, w_sign_b;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic w_is_div, w_is_acc, w_is_sub;
    logic w_accept;

    assign w_signed = ~funct[0];
    assign w_sign_a = w_signed & a[WIDTH-1];
    assign w_sign_b = w_signed & b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -a : a;
    assign w_mag_b  = w_sign_b ? -b : b;

    assign w_is_div = (r_op[2:1] == 2'b01);
    assign w_is_acc = r_op[2];
    assign w_is_sub = r_op[1];

    // A new operation is taken from IDLE, or straight out of DONE when not parked
    assign w_accept = start && !clear &&
                      ((r_state == c_IDLE) || ((r_state == c_DONE) && !hold_result));

    // Multiply step: multiplier shifts out of r_lo, partial product grows in r_hi
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Restoring divide step: dividend shifts out of r_lo into the remainder,
    // quotient bits shift into r_lo from the bottom
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff, w_div_hi, w_div_lo;

    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_diff   = w_shift[WIDTH-1:0] - r_b;
    assign w_div_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

    // Sign correction and accumulation (all sums wrap modulo 2^(2*WIDTH))
    logic [2*WIDTH-1:0] w_prod, w_prod_s, w_acc, w_mac, w_mul_res;
    logic [WIDTH-1:0]   w_quo, w_rem;
    logic [WIDTH-1:0]   w_res_hi, w_res_lo;

    assign w_prod    = {r_hi, r_lo};
    assign w_prod_s  = r_neg ? -w_prod : w_prod;
    assign w_acc     = {r_acc_hi, r_acc_lo};
    assign w_mac     = w_is_sub ? (w_acc - w_prod_s) : (w_acc + w_prod_s);
    assign w_mul_res = w_is_acc ? w_mac : w_prod_s;

    // Divide by zero yields an all-ones quotient regardless of signs; the
    // remainder naturally equals the dividend in that case
    assign w_quo = r_b_zero ? {WIDTH{1'b1}} : (r_neg ? -r_lo : r_lo);
    assign w_rem = r_neg_rem ? -r_hi : r_hi;

    assign w_res_hi = w_is_div ? w_rem : w_mul_res[2*WIDTH-1:WIDTH];
    assign w_res_lo = w_is_div ? w_quo : w_mul_res[WIDTH-1:0];

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 3'd0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_op      <= funct;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            r_b_zero  <= (b == '0);
            r_hi      <= '0;
            r_lo      <= w_mag_a;
            r_b       <= w_mag_b;
            r_acc_hi  <= hi_in;
            r_acc_lo  <= lo_in;
            r_cnt     <= '0;
        end else if (r_state == c_ITER) begin
            r_hi  <= w_is_div ? w_div_hi : w_mul_hi;
            r_lo  <= w_is_div ? w_div_lo : w_mul_lo;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_hi_out <= '0;
            r_lo_out <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_wr <= 1'b0;
                    if (w_accept) begin
                        r_state <= c_ITER;
                        r_busy  <= 1'b1;
                    end
                end
                c_ITER: begin
                    if (clear) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_busy <= 1'b0;
                    if (clear) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_state  <= c_DONE;
                        r_hi_out <= w_res_hi;
                        r_lo_out <= w_res_lo;
                        r_done   <= 1'b1;
                        r_wr     <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_wr <= 1'b0;
                    if (w_accept) begin
                        r_state <= c_ITER;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else if (clear || !hold_result) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out      = r_hi_out;
    assign lo_out      = r_lo_out;
    assign busy        = r_busy;
    assign done        = r_done;
    assign write_hi_lo = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_iter_unit
//  Description : Directed self-checking bench for muldiv_iter_unit (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, clear, hold_result;
    logic [2:0]   funct;
    logic [W-1:0] a, b, hi_in, lo_in;
    logic [W-1:0] hi_out, lo_out;
    logic         busy, done, write_hi_lo;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .clear       (clear),
        .hold_result (hold_result),
        .a           (a),
        .b           (b),
        .hi_in       (hi_in),
        .lo_in       (lo_in),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .write_hi_lo (write_hi_lo)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] flags();
        return {61'b0, busy, done, write_hi_lo};
    endfunction

    // Pulse start for one cycle, then scramble operands to prove they were captured
    task automatic launch(input logic [2:0] f, input logic [W-1:0] ia, ib, ihi, ilo);
        funct = f; a = ia; b = ib; hi_in = ihi; lo_in = ilo;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
    endtask

    // Called in cycle 1; returns in cycle 34 with the result in DONE
    task automatic wait_done(input string tag, input logic [W-1:0] eh, el, input bit inject);
        for (int k = 1; k <= 33; k++) begin
            check($sformatf("%s busy c%0d", tag, k), flags(), 64'b100);
            if (inject && k == 5) begin
                start = 1'b1; funct = 3'd3; a = 32'd100; b = 32'd7;
            end
            if (inject && k == 6) start = 1'b0;
            tick();
        end
        check({tag, " flags"}, flags(), 64'b011);
        check({tag, " hi"}, {32'b0, hi_out}, {32'b0, eh});
        check({tag, " lo"}, {32'b0, lo_out}, {32'b0, el});
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [W-1:0] ia, ib, ihi, ilo, eh, el);
        launch(f, ia, ib, ihi, ilo);
        wait_done(tag, eh, el, 1'b0);
        tick();
        check({tag, " idle"}, flags(), 64'b000);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0; hold_result = 1'b0;
        funct = 3'd0; a = '0; b = '0; hi_in = '0; lo_in = '0;
        @(negedge clk);
        tick(); tick(); tick();
        check("reset flags", flags(), 64'b000);
        check("reset hi", {32'b0, hi_out}, 64'h0);
        check("reset lo", {32'b0, lo_out}, 64'h0);
        reset = 1'b0;
        tick();

        run_op("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult neg",  3'd0, 32'hFFFFFFFD, 32'h5, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div neg",   3'd2, 32'hFFFFFFF9, 32'h2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu zero", 3'd3, 32'h7, 32'h0, 0, 0, 32'h7, 32'hFFFFFFFF);
        run_op("div zero",  3'd2, 32'hFFFFFFFB, 32'h0, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000);
        run_op("madd",      3'd4, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
        run_op("msubu",     3'd7, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("msub neg",  3'd6, 32'hFFFFFFFE, 32'h3, 32'h0, 32'hA, 32'h0, 32'h10);

        // Clear while DONE is parked: drops done, keeps result
        launch(3'd3, 32'd100, 32'd7, 0, 0);
        wait_done("divu", 32'd2, 32'd14, 1'b0);
        clear = 1'b1; hold_result = 1'b1;
        tick();
        clear = 1'b0; hold_result = 1'b0;
        check("clear in done flags", flags(), 64'b000);
        check("clear in done lo", {32'b0, lo_out}, 64'd14);

        run_op("multu", 3'd1, 32'h12345678, 32'h10, 0, 0, 32'h1, 32'h23456780);

        // Clear in cycle 10 of a MULTU
        launch(3'd1, 32'd2, 32'd3, 0, 0);
        for (int k = 1; k < 10; k++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("clear flags %0d", k), flags(), 64'b000);
            check($sformatf("clear hi %0d", k), {32'b0, hi_out}, 64'h1);
            check($sformatf("clear lo %0d", k), {32'b0, lo_out}, 64'h23456780);
            tick();
        end

        // clear and start together: clear wins
        clear = 1'b1; start = 1'b1; funct = 3'd1; a = 32'd9; b = 32'd9;
        tick();
        clear = 1'b0; start = 1'b0;
        check("clear+start c1", flags(), 64'b000);
        tick();
        check("clear+start c2", flags(), 64'b000);

        // Reset in cycle 10 of an operation
        launch(3'd1, 32'hFFFFFFFF, 32'h2, 0, 0);
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        check("midop reset flags", flags(), 64'b000);
        check("midop reset hi", {32'b0, hi_out}, 64'h0);
        check("midop reset lo", {32'b0, lo_out}, 64'h0);
        reset = 1'b0;
        tick();

        // Hold in DONE for 5 cycles, then back-to-back start with an ignored start mid-op
        launch(3'd1, 32'd3, 32'd4, 0, 0);
        wait_done("hold op", 32'd0, 32'd12, 1'b0);
        hold_result = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold c%0d", k), flags(), 64'b010);
            check($sformatf("hold lo c%0d", k), {32'b0, lo_out}, 64'd12);
        end
        hold_result = 1'b0;
        launch(3'd1, 32'd5, 32'd6, 0, 0);
        wait_done("b2b", 32'd0, 32'd30, 1'b1);
        tick();
        check("b2b idle", flags(), 64'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
